// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Single-cycle 32x32 multiply; 32-iteration radix-2 restoring divide.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic        mult,
    input  logic        div,
    input  logic        mdsign,
    input  logic [1:0]  hilowen,
    input  logic [1:0]  hiloren,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    output logic        stall,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] b_mag, quot, rem;
    logic [63:0] prod;
    logic        op_signed, op_div, a_neg, b_neg;

    logic        start, hilo_wr, neg_q;
    logic [31:0] a_mag_c, b_mag_c, quot_fix, rem_fix;
    logic [32:0] rem_shift, rem_trial;
    logic [63:0] prod_fix;

    assign start   = (state == IDLE) && en && !flush && (mult || div);
    assign hilo_wr = (state == IDLE) && en && !flush && !mult && !div && (|hilowen);

    assign a_mag_c = (mdsign && rega[31]) ? -rega : rega;
    assign b_mag_c = (mdsign && regb[31]) ? -regb : regb;

    // quot starts as the dividend and shifts out MSB-first while quotient bits shift in
    assign rem_shift = {rem, quot[31]};
    assign rem_trial = rem_shift - {1'b0, b_mag};

    assign neg_q    = op_signed && (a_neg ^ b_neg);
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -quot : quot;
    assign rem_fix  = (op_signed && a_neg) ? -rem : rem;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = mult ? MUL : DIV;
                end
            end
            MUL: begin
                stall     = 1'b1;
                state_nxt = DONE;
            end
            DIV: begin
                stall = 1'b1;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            stall     = 1'b0;
            state_nxt = IDLE;
        end
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quot      <= a_mag_c;
                        b_mag     <= b_mag_c;
                        rem       <= '0;
                        cnt       <= '0;
                        op_signed <= mdsign;
                        op_div    <= !mult;
                        a_neg     <= rega[31];
                        b_neg     <= regb[31];
                    end else if (hilo_wr) begin
                        if (hilowen[1]) hi <= rega;
                        if (hilowen[0]) lo <= rega;
                    end
                end
                MUL: prod <= 64'(quot) * 64'(b_mag);
                DIV: begin
                    cnt <= cnt + 5'd1;
                    if (!rem_trial[32]) begin
                        rem  <= rem_trial[31:0];
                        quot <= {quot[30:0], 1'b1};
                    end else begin
                        rem  <= rem_shift[31:0];
                        quot <= {quot[30:0], 1'b0};
                    end
                end
                DONE: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hilo_rdata = '0;
        if (hiloren[1])      hilo_rdata = hi;
        else if (hiloren[0]) hilo_rdata = lo;
    end

endmodule
